// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the pulse-driven SRAM controller
// Contents: FSM state enum, RV32I load/store width codes, pulse counter width,
// and the funct3 legality helper used by the request decoder.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for PULSE_W up to 15.
    localparam int CNT_W = 4;

    // Stores only have signed-width codes; loads additionally allow BU/HU.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return !ok;
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// rtl/sram_lane_align.sv - byte-lane steering for SRAM writes and load extraction
// Ports:
//   funct3_i   : RV32I width/sign code
//   addr_i     : low two bits of the byte address
//   wdata_i    : LSB-aligned store data
//   rdata_i    : raw 32-bit word read from the macro
//   byte_sel_o : byte-lane enable for the access
//   datain_o   : store data replicated across all lanes
//   rdata_o    : selected lane, sign- or zero-extended
module sram_lane_align
    import sram_ctrl_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_sel_o,
    output logic [31:0] datain_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane  = rdata_i[{addr_i, 3'b000} +: 8];
        // Halfwords only look at addr[1]; addr[0] is either truncated or
        // rejected upstream as misaligned.
        half_lane  = rdata_i[{addr_i[1], 4'b0000} +: 16];
        byte_sel_o = 4'hF;
        datain_o   = wdata_i;
        rdata_o    = rdata_i;
        case (funct3_i[1:0])
            F3_B[1:0]: begin
                byte_sel_o = 4'b0001 << addr_i;
                datain_o   = {4{wdata_i[7:0]}};
                rdata_o    = funct3_i[2] ? {24'h0, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
            end
            F3_H[1:0]: begin
                byte_sel_o = 4'b0011 << {addr_i[1], 1'b0};
                datain_o   = {2{wdata_i[15:0]}};
                rdata_o    = funct3_i[2] ? {16'h0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - LSU-side controller for the 128x32 pulse-driven SRAM macro
// Optional build macro: SRAM_CTRL_MISALIGN_EN (reject misaligned half/word accesses).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_funct3, req_wdata      : store flag, byte address, width code, store data
//   resp_valid, resp_rdata,
//   resp_err                   : one-cycle response strobe, load data, error flag
//   sram_addr_sel, sram_byte_sel,
//   sram_datain                : registered word select, lane enable, write data
//   sram_read_pulse,
//   sram_write_pulse           : registered access strobes, PULSE_W cycles wide
//   sram_dataout               : raw read word from the macro
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int PULSE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] sram_addr_sel,
    output logic [3:0]        sram_byte_sel,
    output logic              sram_read_pulse,
    output logic              sram_write_pulse,
    output logic [31:0]       sram_datain,
    input  logic [31:0]       sram_dataout
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_sel_q;
    logic [3:0]        byte_sel_q;
    logic [31:0]       datain_q, rdata_q;
    logic              rd_pulse_q, wr_pulse_q;
    logic              req_err;
    logic [2:0]        al_f3;
    logic [1:0]        al_addr;
    logic [3:0]        al_bsel;
    logic [31:0]       al_din, al_rdata;

    always_comb begin
        req_err = f3_illegal(req_we, req_funct3);
`ifdef SRAM_CTRL_MISALIGN_EN
        if (req_funct3[1:0] == F3_H[1:0] && req_addr[0]) begin
            req_err = 1'b1;
        end
        if (req_funct3[1:0] == F3_W[1:0] && req_addr[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
`endif
    end

    // One aligner serves both directions: in IDLE it sees the incoming
    // request (write lane/byte_sel), afterwards the latched request so the
    // captured read word is extracted during RESP.
    always_comb begin
        al_f3   = (state_q == IDLE) ? req_funct3    : f3_q;
        al_addr = (state_q == IDLE) ? req_addr[1:0] : lane_q;
    end

    sram_lane_align u_align (
        .funct3_i   (al_f3),
        .addr_i     (al_addr),
        .wdata_i    (req_wdata),
        .rdata_i    (rdata_q),
        .byte_sel_o (al_bsel),
        .datain_o   (al_din),
        .rdata_o    (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = req_err ? RESP : SETUP;
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !we_q) ? al_rdata : 32'h0;
    end

    // Pulses are flops keyed off the next state, so they rise on the
    // SETUP->PULSE edge and fall on the edge leaving PULSE (or on reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= 3'b000;
            lane_q     <= 2'b00;
            addr_sel_q <= '0;
            byte_sel_q <= 4'h0;
            datain_q   <= 32'h0;
            rdata_q    <= 32'h0;
            rd_pulse_q <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            rd_pulse_q <= (state_d == PULSE) && !we_q;
            wr_pulse_q <= (state_d == PULSE) && we_q;
            if (state_q == IDLE && req_valid) begin
                we_q   <= req_we;
                err_q  <= req_err;
                f3_q   <= req_funct3;
                lane_q <= req_addr[1:0];
                if (!req_err) begin
                    addr_sel_q <= req_addr[ADDR_W+1:2];
                    byte_sel_q <= al_bsel;
                    datain_q   <= al_din;
                end
            end
            if (state_q == PULSE && state_d == RESP && !we_q) begin
                rdata_q <= sram_dataout;
            end
        end
    end

    assign sram_addr_sel    = addr_sel_q;
    assign sram_byte_sel    = byte_sel_q;
    assign sram_datain      = datain_q;
    assign sram_read_pulse  = rd_pulse_q;
    assign sram_write_pulse = wr_pulse_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with an SRAM macro model
module tb_sram_ctrl;

    localparam int ADDR_W = 7;
    localparam int PW     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [6:0]  sram_addr_sel;
    logic [3:0]  sram_byte_sel;
    logic        sram_read_pulse;
    logic        sram_write_pulse;
    logic [31:0] sram_datain;
    logic [31:0] sram_dataout;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(ADDR_W), .PULSE_W(PW)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_funct3       (req_funct3),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .sram_addr_sel    (sram_addr_sel),
        .sram_byte_sel    (sram_byte_sel),
        .sram_read_pulse  (sram_read_pulse),
        .sram_write_pulse (sram_write_pulse),
        .sram_datain      (sram_datain),
        .sram_dataout     (sram_dataout)
    );

    // Macro model: data is only presented while read_pulse is high.
    logic [31:0] mem     [128];
    logic [31:0] ref_mem [128];
    assign sram_dataout = sram_read_pulse ? mem[sram_addr_sel] : 32'hBAD0_F00D;

    always @(posedge clk) begin
        if (sram_write_pulse) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_byte_sel[i]) mem[sram_addr_sel][8*i +: 8] <= sram_datain[8*i +: 8];
            end
        end
    end

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'hA5, 8'h3C, b};
    endfunction

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model state for the one outstanding transaction.
    bit          act = 0;
    int          acc_cyc = 0, prev_acc = 0, last_gap = 0, kk = 0;
    int          n_acc = 0, n_resp = 0, pcnt = 0;
    logic        e_we, e_err;
    int          e_lat;
    logic [6:0]  e_asel;
    logic [3:0]  e_bsel;
    logic [31:0] e_din, e_rdata;
    logic [31:0] last_rdata, last_din;
    logic [6:0]  last_asel;
    logic [3:0]  last_bsel;
    logic        last_err;
    int          last_lat, last_pcnt;
    int          l, sz, wi;
    logic [31:0] word, v;

    always @(negedge clk) begin
        if (rst) begin
            act = 0;
        end else if (act) begin
            kk = cyc - acc_cyc;
            chk("busy_ready", req_ready, 0);
            if (kk >= 1 && kk <= PW && !e_err) begin
                chk("wr_pulse", sram_write_pulse, e_we);
                chk("rd_pulse", sram_read_pulse, !e_we);
            end else begin
                chk("wr_pulse_low", sram_write_pulse, 0);
                chk("rd_pulse_low", sram_read_pulse, 0);
            end
            if (!e_err) begin
                chk("addr_sel", sram_addr_sel, e_asel);
                chk("byte_sel", sram_byte_sel, e_bsel);
                if (kk <= PW) chk("datain", sram_datain, e_din);
            end
            if (sram_read_pulse || sram_write_pulse) begin
                pcnt++;
                last_asel = sram_addr_sel;
                last_bsel = sram_byte_sel;
                last_din  = sram_datain;
            end
            if (kk >= e_lat) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_err", resp_err, e_err);
                chk("resp_rdata", resp_rdata, e_rdata);
                last_rdata = resp_rdata;
                last_err   = resp_err;
                last_lat   = kk + 1;
                last_pcnt  = pcnt;
                n_resp++;
                act = 0;
            end else begin
                chk("resp_valid_low", resp_valid, 0);
            end
        end else begin
            chk("idle_ready", req_ready, 1);
            chk("idle_wr_pulse", sram_write_pulse, 0);
            chk("idle_rd_pulse", sram_read_pulse, 0);
            chk("idle_resp_valid", resp_valid, 0);
            if (req_valid) begin
                e_we   = req_we;
                wi     = int'(req_addr[8:2]);
                l      = int'(req_addr[1:0]);
                sz     = int'(req_funct3[1:0]);
                e_asel = req_addr[8:2];
                if (req_we) e_err = !(req_funct3 inside {3'd0, 3'd1, 3'd2});
                else        e_err = !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef SRAM_CTRL_MISALIGN_EN
                if (sz == 1 && l % 2 == 1) e_err = 1'b1;
                if (sz == 2 && l != 0)     e_err = 1'b1;
`endif
                e_lat = e_err ? 0 : PW + 1;
                if (sz == 0) begin
                    e_bsel = 4'(1 << l);
                    e_din  = {24'h0, req_wdata[7:0]} * 32'h0101_0101;
                end else if (sz == 1) begin
                    e_bsel = 4'(3 << (l / 2 * 2));
                    e_din  = {16'h0, req_wdata[15:0]} * 32'h0001_0001;
                end else begin
                    e_bsel = 4'hF;
                    e_din  = req_wdata;
                end
                word = ref_mem[wi];
                if (sz == 0) begin
                    v = (word >> (8 * l)) & 32'hFF;
                    if (!req_funct3[2] && v[7]) v = v | 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    v = (word >> (16 * (l / 2))) & 32'hFFFF;
                    if (!req_funct3[2] && v[15]) v = v | 32'hFFFF_0000;
                end else begin
                    v = word;
                end
                e_rdata = (e_we || e_err) ? 32'h0 : v;
                if (e_we && !e_err) begin
                    if (sz == 0)      ref_mem[wi][8*l +: 8]        = req_wdata[7:0];
                    else if (sz == 1) ref_mem[wi][16*(l/2) +: 16]  = req_wdata[15:0];
                    else              ref_mem[wi]                  = req_wdata;
                end
                acc_cyc  = cyc + 1;
                last_gap = acc_cyc - prev_acc;
                prev_acc = acc_cyc;
                pcnt     = 0;
                n_acc++;
                act = 1;
            end
        end
    end

    task automatic wait_acc(input int s_acc);
        int t;
        t = 0;
        while (n_acc == s_acc && t < 50) begin
            @(posedge clk);
            t++;
        end
        if (n_acc == s_acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic wait_resp(input int target);
        int t;
        t = 0;
        while (n_resp < target && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (n_resp < target) begin
            vectors++;
            miscompares++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", n_resp, target);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] wd);
        int s_acc, s_resp;
        @(posedge clk);
        #1;
        s_acc  = n_acc;
        s_resp = n_resp;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        wait_acc(s_acc);
        #1 req_valid = 1'b0;
        wait_resp(s_resp + 1);
    endtask

    initial begin
        int s_acc, s_resp;
        logic [2:0] f3;
        logic       we;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_pulses", {sram_read_pulse, sram_write_pulse}, 0);
        chk("rst_addr_sel", sram_addr_sel, 0);
        chk("rst_byte_sel", sram_byte_sel, 0);
        chk("rst_datain", sram_datain, 0);
        chk("rst_resp", {resp_valid, resp_err}, 0);
        chk("rst_rdata", resp_rdata, 0);
        rst = 1'b0;

        do_req(1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF);
        chk("sw_asel", last_asel, 4);
        chk("sw_bsel", last_bsel, 4'hF);
        chk("sw_din", last_din, 32'hDEAD_BEEF);
        chk("sw_pulse_cycles", last_pcnt, 3);
        chk("sw_latency", last_lat, 5);
        chk("sw_rdata", last_rdata, 0);

        do_req(1'b1, 3'b000, 9'h013, 32'h0000_00A5);
        chk("sb_bsel", last_bsel, 4'b1000);
        chk("sb_din", last_din, 32'hA5A5_A5A5);
        do_req(1'b0, 3'b000, 9'h013, 32'h0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FFA5);
        do_req(1'b0, 3'b100, 9'h013, 32'h0);
        chk("lbu_rdata", last_rdata, 32'h0000_00A5);

        do_req(1'b1, 3'b001, 9'h022, 32'h0000_8001);
        chk("sh_bsel", last_bsel, 4'b1100);
        do_req(1'b0, 3'b001, 9'h022, 32'h0);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'b101, 9'h022, 32'h0);
        chk("lhu_rdata", last_rdata, 32'h0000_8001);
        do_req(1'b0, 3'b010, 9'h020, 32'h0);
        chk("lw_upper", last_rdata >> 16, 32'h0000_8001);

        do_req(1'b0, 3'b011, 9'h040, 32'h0);
        chk("bad_f3_err", last_err, 1);
        chk("bad_f3_rdata", last_rdata, 0);
        chk("bad_f3_pulses", last_pcnt, 0);
        chk("bad_f3_latency", last_lat, 1);

        do_req(1'b0, 3'b001, 9'h021, 32'h0);
`ifdef SRAM_CTRL_MISALIGN_EN
        chk("mis_lh_err", last_err, 1);
        chk("mis_lh_pulses", last_pcnt, 0);
`else
        chk("mis_lh_err", last_err, 0);
        chk("mis_lh_rdata", last_rdata, 32'h0000_3C08);
`endif

        do_req(1'b0, 3'b010, 9'h1FC, 32'h0);
        chk("lw_top_asel", last_asel, 127);
        chk("lw_top_pulses", last_pcnt, 3);
        chk("lw_top_latency", last_lat, 5);
        chk("lw_top_rdata", last_rdata, 32'h7FDA_3C7F);

        // Reset during the second read-pulse cycle.
        @(posedge clk);
        #1;
        s_acc  = n_acc;
        s_resp = n_resp;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h1FC;
        req_valid = 1'b1;
        wait_acc(s_acc);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_pulse_high", sram_read_pulse, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pulse_drop", sram_read_pulse, 0);
        chk("rst_no_valid", resp_valid, 0);
        chk("rst_ready_back", req_ready, 1);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        chk("rst_no_resp", n_resp, s_resp);

        do_req(1'b1, 3'b010, 9'h0A4, 32'h1357_9BDF);
        do_req(1'b0, 3'b010, 9'h0A4, 32'h0);
        chk("b2b_rdata", last_rdata, 32'h1357_9BDF);

        // Held request: the second accept lands one cycle after RESP.
        @(posedge clk);
        #1;
        s_acc  = n_acc;
        s_resp = n_resp;
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h0A4;
        req_valid = 1'b1;
        wait_acc(s_acc);
        wait_acc(s_acc + 1);
        #1 req_valid = 1'b0;
        chk("held_gap", last_gap, 6);
        wait_resp(s_resp + 2);
        chk("held_rdata", last_rdata, 32'h1357_9BDF);

        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            do_req(we, f3, 9'($urandom_range(0, 511)), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
